// File: rtl/vec_linalg_pkg.sv
// rtl/vec_linalg_pkg.sv - shared constants and width helpers for the covariance estimator
//   Default parameter values, derived width/point helpers, output saturation bounds,
//   and the valid/last flag record carried down the sample pipeline.
package vec_linalg_pkg;

  localparam int DEF_DIN_WIDTH  = 8;
  localparam int DEF_DIN_POINT  = 7;
  localparam int DEF_ACC_LOG    = 10;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_DOUT_POINT = 15;

  // Full-precision product of two signed samples.
  function automatic int prod_width(input int din_w);
    return 2 * din_w;
  endfunction

  function automatic int prod_point(input int din_p);
    return 2 * din_p;
  endfunction

  // Sum of 2^acc_log products cannot overflow this width.
  function automatic int acc_width(input int din_w, input int acc_log);
    return 2 * din_w + acc_log;
  endfunction

  function automatic longint frame_len(input int acc_log);
    return longint'(1) << acc_log;
  endfunction

  // Saturation bounds for an unsigned / signed output of width w.
  function automatic longint umax(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } flag_t;

endpackage

// File: rtl/cov_mac.sv
// rtl/cov_mac.sv - one multiply/accumulate/dump lane of the covariance estimator
//   clk, rst        : clock, synchronous active-low reset
//   a, b            : registered signed samples to multiply
//   valid, last     : flags aligned with a/b; last marks the final sample of a frame
//   dump            : frame sum (acc + final product), ACC_W bits signed
//   dump_valid      : one-cycle pulse when dump is new
module cov_mac
  import vec_linalg_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int ACC_LOG   = DEF_ACC_LOG,
  parameter int ACC_W     = acc_width(DIN_WIDTH, ACC_LOG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] a,
  input  logic [DIN_WIDTH-1:0] b,
  input  logic                 valid,
  input  logic                 last,
  output logic [ACC_W-1:0]     dump,
  output logic                 dump_valid
);

  localparam int PW = prod_width(DIN_WIDTH);

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod_q;
  flag_t                   prod_flag;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_next;

  assign a_ext    = {{DIN_WIDTH{a[DIN_WIDTH-1]}}, a};
  assign b_ext    = {{DIN_WIDTH{b[DIN_WIDTH-1]}}, b};
  assign prod_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
  assign acc_next = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q     <= '0;
      prod_flag  <= '0;
      acc        <= '0;
      dump       <= '0;
      dump_valid <= 1'b0;
    end else begin
      prod_q          <= a_ext * b_ext;
      prod_flag.valid <= valid;
      prod_flag.last  <= valid && last;
      dump_valid      <= prod_flag.valid && prod_flag.last;
      if (prod_flag.valid) begin
        if (prod_flag.last) begin
          // Final product goes straight into the dump; the accumulator restarts
          // from zero so the next frame's first sample can arrive next cycle.
          dump <= acc_next;
          acc  <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/covariance_acc.sv
// rtl/covariance_acc.sv - streaming 2x2 real covariance estimator (r11, r22, r12 per frame)
//   clk, rst        : clock, synchronous active-low reset
//   x1, x2          : signed antenna samples, DIN_POINT fractional bits
//   din_valid       : qualifies x1/x2; no backpressure
//   r11, r22        : unsigned frame means of x1^2, x2^2, DOUT_POINT fractional bits
//   r12             : signed frame mean of x1*x2
//   dout_valid      : one-cycle pulse when r11/r22/r12 are new
//   sat             : set with dout_valid if any output saturated in that frame
module covariance_acc
  import vec_linalg_pkg::*;
#(
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int DIN_POINT  = DEF_DIN_POINT,
  parameter int ACC_LOG    = DEF_ACC_LOG,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int DOUT_POINT = DEF_DOUT_POINT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  x1,
  input  logic [DIN_WIDTH-1:0]  x2,
  input  logic                  din_valid,
  output logic [DOUT_WIDTH-1:0] r11,
  output logic [DOUT_WIDTH-1:0] r22,
  output logic [DOUT_WIDTH-1:0] r12,
  output logic                  dout_valid,
  output logic                  sat
);

  localparam int     ACC_W      = acc_width(DIN_WIDTH, ACC_LOG);
  localparam int     PROD_POINT = prod_point(DIN_POINT);
  localparam int     SHL        = (DOUT_POINT > PROD_POINT) ? DOUT_POINT - PROD_POINT : 0;
  localparam int     SHR        = (PROD_POINT > DOUT_POINT) ? PROD_POINT - DOUT_POINT : 0;
  localparam longint U_MAX      = umax(DOUT_WIDTH);
  localparam longint S_MAX      = smax(DOUT_WIDTH);
  localparam longint S_MIN      = smin(DOUT_WIDTH);

  logic [ACC_LOG-1:0]   cnt;
  logic [DIN_WIDTH-1:0] x1_q;
  logic [DIN_WIDTH-1:0] x2_q;
  flag_t                in_flag;

  logic [ACC_W-1:0] dump11, dump22, dump12;
  logic             dv11, dv22, dv12;
  logic             dump_valid;

  // Input registers, frame counter and last-flag generation. The counter wraps
  // naturally at N-1, so a sample arriving on the wrap cycle opens the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      in_flag <= '0;
    end else begin
      x1_q          <= x1;
      x2_q          <= x2;
      in_flag.valid <= din_valid;
      in_flag.last  <= din_valid && (cnt == {ACC_LOG{1'b1}});
      if (din_valid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  cov_mac #(.DIN_WIDTH(DIN_WIDTH), .ACC_LOG(ACC_LOG), .ACC_W(ACC_W)) u_mac11 (
    .clk(clk), .rst(rst), .a(x1_q), .b(x1_q), .valid(in_flag.valid), .last(in_flag.last),
    .dump(dump11), .dump_valid(dv11)
  );

  cov_mac #(.DIN_WIDTH(DIN_WIDTH), .ACC_LOG(ACC_LOG), .ACC_W(ACC_W)) u_mac22 (
    .clk(clk), .rst(rst), .a(x2_q), .b(x2_q), .valid(in_flag.valid), .last(in_flag.last),
    .dump(dump22), .dump_valid(dv22)
  );

  cov_mac #(.DIN_WIDTH(DIN_WIDTH), .ACC_LOG(ACC_LOG), .ACC_W(ACC_W)) u_mac12 (
    .clk(clk), .rst(rst), .a(x1_q), .b(x2_q), .valid(in_flag.valid), .last(in_flag.last),
    .dump(dump12), .dump_valid(dv12)
  );

  // All lanes see identical flags, so their dump pulses coincide.
  assign dump_valid = dv11 & dv22 & dv12;

  // Mean by arithmetic shift (floor), then move the binary point to DOUT_POINT.
  function automatic logic signed [63:0] realign(input logic [ACC_W-1:0] d);
    logic signed [63:0] v;
    v = {{(64-ACC_W){d[ACC_W-1]}}, d};
    v = v >>> ACC_LOG;
    v = v <<< SHL;
    v = v >>> SHR;
    return v;
  endfunction

  logic signed [63:0]    a11, a22, a12;
  logic [DOUT_WIDTH-1:0] r11_d, r22_d, r12_d;
  logic                  s11, s22, s12;

  always_comb begin
    a11   = realign(dump11);
    a22   = realign(dump22);
    a12   = realign(dump12);
    r11_d = a11[DOUT_WIDTH-1:0];
    r22_d = a22[DOUT_WIDTH-1:0];
    r12_d = a12[DOUT_WIDTH-1:0];
    s11   = 1'b0;
    s22   = 1'b0;
    s12   = 1'b0;
    if (a11 > U_MAX) begin
      r11_d = {DOUT_WIDTH{1'b1}};
      s11   = 1'b1;
    end else if (a11 < 0) begin
      r11_d = '0;
      s11   = 1'b1;
    end
    if (a22 > U_MAX) begin
      r22_d = {DOUT_WIDTH{1'b1}};
      s22   = 1'b1;
    end else if (a22 < 0) begin
      r22_d = '0;
      s22   = 1'b1;
    end
    if (a12 > S_MAX) begin
      r12_d = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      s12   = 1'b1;
    end else if (a12 < S_MIN) begin
      r12_d = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      s12   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r11        <= '0;
      r22        <= '0;
      r12        <= '0;
      sat        <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= dump_valid;
      if (dump_valid) begin
        r11 <= r11_d;
        r22 <= r22_d;
        r12 <= r12_d;
        sat <= s11 | s22 | s12;
      end
    end
  end

endmodule

// File: tb/tb_covariance_acc.sv
// tb/tb_covariance_acc.sv - self-checking bench for covariance_acc (N=4 frames)
module tb_covariance_acc;

  localparam int DW = 8;
  localparam int DP = 7;
  localparam int AL = 2;
  localparam int OW = 16;
  localparam int OP = 15;
  localparam int N  = 1 << AL;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] x1, x2;
  logic          din_valid;
  logic [OW-1:0] r11, r22, r12;
  logic          dout_valid, sat;

  covariance_acc #(
    .DIN_WIDTH(DW), .DIN_POINT(DP), .ACC_LOG(AL), .DOUT_WIDTH(OW), .DOUT_POINT(OP)
  ) dut (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .din_valid(din_valid),
    .r11(r11), .r22(r22), .r12(r12), .dout_valid(dout_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pulse = -100;
  int prev_pulse = -100;

  typedef struct {
    int          at_cyc;
    logic [15:0] e11, e22, e12;
    logic        esat;
  } pend_t;

  pend_t pend[$];
  int    fa[$];
  int    fb[$];

  logic [15:0] h11 = '0, h22 = '0, h12 = '0;
  logic        hsat = 1'b0, hval = 1'b0;

  typedef struct {
    logic [7:0]  a, b;
    logic [15:0] e11, e22, e12;
    logic        esat;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic int floor_div(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // Frame result from plain integer arithmetic: exact sums, floored mean,
  // rescale from point 2*DP to OP, then clamp to the output ranges.
  task automatic close_frame(input int at);
    int    s11, s22, s12, m11, m22, m12;
    pend_t p;
    s11 = 0; s22 = 0; s12 = 0;
    foreach (fa[i]) begin
      s11 += fa[i] * fa[i];
      s22 += fb[i] * fb[i];
      s12 += fa[i] * fb[i];
    end
    m11 = floor_div(s11) * (1 << (OP - 2 * DP));
    m22 = floor_div(s22) * (1 << (OP - 2 * DP));
    m12 = floor_div(s12) * (1 << (OP - 2 * DP));
    p.at_cyc = at;
    p.esat   = 1'b0;
    if (m11 > 65535) begin p.e11 = 16'hFFFF; p.esat = 1'b1; end
    else if (m11 < 0) begin p.e11 = 16'h0000; p.esat = 1'b1; end
    else p.e11 = 16'(m11);
    if (m22 > 65535) begin p.e22 = 16'hFFFF; p.esat = 1'b1; end
    else if (m22 < 0) begin p.e22 = 16'h0000; p.esat = 1'b1; end
    else p.e22 = 16'(m22);
    if (m12 > 32767) begin p.e12 = 16'h7FFF; p.esat = 1'b1; end
    else if (m12 < -32768) begin p.e12 = 16'h8000; p.esat = 1'b1; end
    else p.e12 = 16'(m12);
    pend.push_back(p);
    fa.delete();
    fb.delete();
  endtask

  // One clock: drive, update the model for this edge, then compare #1 later.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    din_valid = v;
    x1        = a;
    x2        = b;
    rst       = r;
    @(posedge clk);
    cyc++;
    hval = 1'b0;
    if (!r) begin
      fa.delete();
      fb.delete();
      pend.delete();
      h11 = '0; h22 = '0; h12 = '0; hsat = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].at_cyc == cyc) begin
        h11  = pend[0].e11;
        h22  = pend[0].e22;
        h12  = pend[0].e12;
        hsat = pend[0].esat;
        hval = 1'b1;
        void'(pend.pop_front());
      end
      if (v) begin
        fa.push_back(int'($signed(a)));
        fb.push_back(int'($signed(b)));
        if (fa.size() == N) close_frame(cyc + 3);
      end
    end
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(hval));
    chk("r11", 32'(r11), 32'(h11));
    chk("r22", 32'(r22), 32'(h22));
    chk("r12", 32'(r12), 32'(h12));
    chk("sat", 32'(sat), 32'(hsat));
    if (dout_valid) begin
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    tbl[0] = '{a: 8'h40, b: 8'h40, e11: 16'h2000, e22: 16'h2000, e12: 16'h2000, esat: 1'b0};
    tbl[1] = '{a: 8'h40, b: 8'hC0, e11: 16'h2000, e22: 16'h2000, e12: 16'hE000, esat: 1'b0};
    tbl[2] = '{a: 8'h80, b: 8'h80, e11: 16'h8000, e22: 16'h8000, e12: 16'h7FFF, esat: 1'b1};

    din_valid = 1'b0; x1 = '0; x2 = '0; rst = 1'b0;
    step(1'b1, 8'h40, 8'h40, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    chk("reset r11", 32'(r11), 32'h0);
    chk("reset dout_valid", 32'(dout_valid), 32'h0);

    // Constant-input frames with fixed expected results.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) step(1'b1, tbl[i].a, tbl[i].b, 1'b1);
      idle(3);
      chk("tbl dout_valid", 32'(dout_valid), 32'h1);
      chk("tbl r11", 32'(r11), 32'(tbl[i].e11));
      chk("tbl r22", 32'(r22), 32'(tbl[i].e22));
      chk("tbl r12", 32'(r12), 32'(tbl[i].e12));
      chk("tbl sat", 32'(sat), 32'(tbl[i].esat));
      idle(2);
      chk("tbl hold r11", 32'(r11), 32'(tbl[i].e11));
    end

    // Sparse valid: one sample every third cycle.
    for (int k = 0; k < N; k++) begin
      step(1'b1, 8'h40, 8'h40, 1'b1);
      if (k < N - 1) idle(2);
    end
    idle(2);
    chk("sparse dout_valid early", 32'(dout_valid), 32'h0);
    idle(1);
    chk("sparse dout_valid", 32'(dout_valid), 32'h1);
    chk("sparse r12", 32'(r12), 32'h2000);
    idle(2);

    // Partial frame discarded by reset.
    step(1'b1, 8'h40, 8'h40, 1'b1);
    step(1'b1, 8'h40, 8'h40, 1'b1);
    step(1'b1, 8'h40, 8'h40, 1'b0);
    chk("post-reset r11", 32'(r11), 32'h0);
    for (int k = 0; k < N; k++) step(1'b1, 8'h20, 8'h20, 1'b1);
    idle(3);
    chk("fresh dout_valid", 32'(dout_valid), 32'h1);
    chk("fresh r11", 32'(r11), 32'h0800);
    chk("fresh r12", 32'(r12), 32'h0800);
    idle(2);

    // Back-to-back frames across the counter wrap.
    for (int k = 0; k < N; k++) step(1'b1, 8'h40, 8'h40, 1'b1);
    for (int k = 0; k < N; k++) begin
      step(1'b1, 8'h20, 8'h20, 1'b1);
      if (k == 2) begin
        chk("b2b first dout_valid", 32'(dout_valid), 32'h1);
        chk("b2b first r11", 32'(r11), 32'h2000);
      end
    end
    idle(3);
    chk("b2b second dout_valid", 32'(dout_valid), 32'h1);
    chk("b2b second r22", 32'(r22), 32'h0800);
    chk("b2b pulse spacing", 32'(last_pulse - prev_pulse), 32'd4);
    idle(2);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 79) != 0);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/covariance_acc.md
Name: covariance_acc

Overview:
- Streaming 2x2 real covariance estimator for the UESPRIT DoA chain.
- Takes paired antenna samples x1, x2 and averages x1², x2² and x1·x2 over a frame of 2^ACC_LOG valid samples.
- Emits r11, r22, r12 with a one-cycle valid pulse per frame.
- Acts as the producer end of the eigen solver's r11/r22/r12/din_valid input interface.

Parameters:
- DIN_WIDTH, 8, sample width (signed).
- DIN_POINT, 7, sample fractional bits.
- ACC_LOG, 10, log2 of frame length N (N = 2^ACC_LOG valid samples).
- DOUT_WIDTH, 16, output width; matches the solver's input width.
- DOUT_POINT, 15, output fractional bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge).
- x1  in  DIN_WIDTH  signed sample, antenna 1.
- x2  in  DIN_WIDTH  signed sample, antenna 2.
- din_valid  in  1  qualifies x1/x2.
- r11  out  DOUT_WIDTH  unsigned mean of x1².
- r22  out  DOUT_WIDTH  unsigned mean of x2².
- r12  out  DOUT_WIDTH  signed mean of x1·x2.
- dout_valid  out  1  one-cycle pulse when r11/r22/r12 are new.
- sat  out  1  high with dout_valid if any output was saturated in that frame.

Behaviour:
- Reset (rst=0):
  - All outputs 0.
  - Sample counter 0; accumulators 0; pipeline valid/last flags cleared.
  - Any partial frame is discarded.
- Only cycles with din_valid=1 count. Gaps of any length are allowed; no backpressure.
- Pipeline for sample accepted at cycle t:
  - t+1: inputs registered.
  - t+2: products registered. Width 2*DIN_WIDTH, point 2*DIN_POINT, full precision, signed.
  - t+3: accumulate. Accumulator width ACC_W = 2*DIN_WIDTH+ACC_LOG, so no internal overflow.
  - t+4: output register.
- Counter counts valid samples 0..N-1 and wraps. The sample at count N-1 carries a `last` flag down the pipeline with its valid.
- On `last` at the accumulate stage:
  - Dump register takes acc + product.
  - Accumulator loads 0 in the same cycle, so the next frame starts gap-free; back-to-back frames are legal.
- Output stage, the cycle after the dump:
  - Mean = dump >>> ACC_LOG (arithmetic shift; truncate, no rounding). Point stays 2*DIN_POINT.
  - Realign to DOUT_POINT by shifting left or right (truncate).
  - Saturate:
    - r11/r22 to [0, 2^DOUT_WIDTH-1].
    - r12 to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
- Latency: dout_valid=1 exactly 4 cycles after the din_valid cycle of the Nth sample. It is 0 otherwise.
- r11/r22/r12/sat hold their values until the next dout_valid.
- Reset asserted in the same cycle as a `last` sample: reset wins and no pulse is produced.
- din_valid during reset is ignored.
- Counter wrap and output dump occurring in the same cycle as a new valid sample: the new sample goes to the next frame and is not lost.

Decomposition:
- Shared package (vec_linalg_pkg):
  - ACC_W and N derived constants.
  - Product width/point localparams.
  - Saturation bound constants for unsigned and signed outputs.
- Natural sub-module: cov_mac, one multiply → accumulate → dump lane with a `last` input. Instantiated three times (x1·x1, x2·x2, x1·x2).
- Top level holds: input regs, frame counter, `last` pipeline, shift/realign/saturate output stage.

Test Plan (DIN 8/7, DOUT 16/15, ACC_LOG=2 so N=4):
1. x1=x2=0x40 (0.5) for 4 valid cycles → 4 cycles after 4th sample: dout_valid=1, r11=r22=r12=0x2000, sat=0.
2. x1=0x40, x2=0xC0 (-0.5) ×4 → r11=r22=0x2000, r12=0xE000 (-0.25), sat=0.
3. x1=x2=0x80 (-1.0) ×4 → r11=r22=0x8000, r12 saturates to 0x7FFF, sat=1.
4. Same stimulus as 1 with din_valid high every 3rd cycle → single pulse 4 cycles after 4th valid sample, values as in 1.
5. Two valid samples, then rst=0 for 1 cycle, then 4 samples of 0x20 → no pulse from the partial frame. After the 4 fresh samples: r11=r22=r12=0x0800. Outputs read 0 between reset and that pulse.
6. 8 continuous valid samples (frame A all 0x40, frame B all 0x20) → two pulses exactly 4 cycles apart: 0x2000 then 0x0800. No sample lost at the wrap.
